// File: rtl/sram_pkg.sv
// Shared constants and the read-master state encoding for the SRAM 1R port.
package sram_pkg;

  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_ADDR_WIDTH = 8;
  localparam int SRAM_DEPTH      = 1 << SRAM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } rd_state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small circular output buffer for returned SRAM words. The head entry drives
// the stream directly; storage clears on reset so the head reads zero.
module sram_rd_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          pop_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          valid_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         count_q;
  logic                  push_ok, pop_ok;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Guard pointers: pushes into a full buffer and pops from an empty one are dropped.
  always_comb begin
    push_ok = push_i && (count_q != CW'(DEPTH));
    pop_ok  = pop_i && (count_q != '0);
  end

  // Storage, pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= inc_ptr(wr_q);
      end
      if (pop_ok) rd_q <= inc_ptr(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head of the buffer is presented as the stream word.
  always_comb begin
    data_o  = mem_q[rd_q];
    valid_o = (count_q != '0);
    count_o = count_q;
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Burst read master for the SRAM 1R port. Issues sequential reads only when
// the output buffer has room for every word already requested, then streams
// the returned data out through a valid/ready interface.
module sram_stream_reader
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] radr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   popped_q, popped_d;
  logic                  inflight_q;
  logic [CW-1:0]         fifo_count;
  logic                  credit_ok, pop;

  // Issue a read only from registered state: RUN, words left, and buffer credit.
  always_comb begin
    credit_ok = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;
    re        = (state_q == RUN) && (issued_q < num_q) && credit_ok;
    radr      = base_q + issued_q[ADDR_WIDTH-1:0];
    pop       = out_valid && out_ready;
    busy      = (state_q != IDLE);
    done      = (state_q == FINISH);
  end

  // Next-state and counter updates for the IDLE -> RUN -> FINISH sequence.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    issued_d = issued_q + {{ADDR_WIDTH{1'b0}}, re};
    popped_d = popped_q + {{ADDR_WIDTH{1'b0}}, pop};
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            base_d   = base_addr;
            num_d    = num_words;
            issued_d = '0;
            popped_d = '0;
            state_d  = RUN;
          end else begin
            state_d = FINISH;
          end
        end
      end
      RUN:     if (popped_q == num_q) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers; the in-flight flag marks that q carries a word next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= re;
    end
  end

  sram_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (inflight_q),
    .data_i  (q),
    .pop_i   (pop),
    .count_o (fifo_count),
    .data_o  (out_data),
    .valid_o (out_valid)
  );

endmodule
